dut: RTL and testbench
======================

DUT -- requirements
Module: dut

Interface
REQ-001 Parameter DATA_W: default 1; width of the A, B and Y data paths.
REQ-002 Parameter A_DEPTH / B_DEPTH: default 2 / 2; entries in input FIFOs A and B.
REQ-003 Parameter Y_DEPTH: default 1; entries in output FIFO Y.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 CLK  input  1  system clock; all state updates on the rising edge.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 write_address  input  3  write target select; 4 = A FIFO, 5 = B FIFO.
REQ-008 write_data  input  DATA_W  data to enqueue.
REQ-009 write_en  input  1  write strobe, sampled on the clock edge.
REQ-010 write_rdy  output  1  write method ready; constant 1 out of reset.
REQ-011 read_address  input  3  read select: 0 = A not-full, 1 = B not-full, 2 = Y not-empty, 3 = Y head data.
REQ-012 read_en  input  1  read strobe; a dequeue takes effect only at address 3.
REQ-013 read_data  output  DATA_W  combinational read result.
REQ-014 read_rdy  output  1  read method ready; constant 1 out of reset.
REQ-015 The internal FIFO flags SHALL be hierarchically visible as a_ff$FULL_N, b_ff$FULL_N and y_ff$EMPTY_N, all active-high.

Function
REQ-016 The block SHALL enqueue write_data into A when write_en=1, write_address=4 and A is not full.
- Same rule for B at write_address=5.
REQ-017 A write to a full FIFO, or to any address other than 4 or 5, SHALL be silently dropped.
- write_rdy stays 1 in that case.
REQ-018 read_data SHALL be combinational from read_address:
- 0 returns a_ff$FULL_N.
- 1 returns b_ff$FULL_N.
- 2 returns y_ff$EMPTY_N.
- 3 returns the Y head when Y is non-empty, else 0.
- Any other address returns 0.
REQ-019 When read_en=1, read_address=3 and Y is non-empty, the block SHALL dequeue Y on the clock edge.
- read_en at any other address, or with Y empty, has no side effect.
REQ-020 On a clock edge where A is non-empty, B is non-empty and Y is not full (all evaluated on pre-edge state), the block SHALL:
- dequeue A and B;
- enqueue (A head OR B head) into Y.
REQ-021 Write-to-Y-visible latency SHALL be 2 edges once both operands are present:
- edge 1 enqueues the operand;
- edge 2 enqueues the result;
- y_ff$EMPTY_N is high after edge 2.
REQ-022 Same-cycle events SHALL all take effect: write to A or B, compute, and Y dequeue.
- The compute uses pre-edge flags, so a Y dequeue does not free space for a same-edge compute when Y_DEPTH=1.
REQ-023 A compute SHALL free space in A and B at the same edge it occurs.
- A write at that edge is accepted only if the pre-edge FULL_N was 1.
REQ-024 FIFOs SHALL be first-in first-out with correct ordering across pointer wrap-around.

Reset
REQ-025 While RST_N=0, all FIFOs SHALL be empty, independent of CLK.
- a_ff$FULL_N=1, b_ff$FULL_N=1, y_ff$EMPTY_N=0.
REQ-026 While RST_N=0, write_rdy and read_rdy SHALL be 1 and read_data SHALL follow REQ-018 on the reset state.
REQ-027 A reset asserted mid-operation SHALL discard all queued data immediately.
- Normal operation resumes on the first rising edge after RST_N=1.

Structure
REQ-028 A shared package SHALL hold the address constants (A_WR=4, B_WR=5, A_STAT=0, B_STAT=1, Y_STAT=2, Y_DATA=3) and the DATA_W default.
REQ-029 The block SHALL use one sub-module, sync_fifo, with parameters WIDTH and DEPTH, instantiated as a_ff, b_ff and y_ff.
- sync_fifo exposes enq, deq, first, FULL_N and EMPTY_N.

Verification
REQ-030 Reset, then read addresses 0/1/2/3 -> read_data 1/1/0/0.
REQ-031 Write A=1 and B=0, wait 2 edges -> addr 2 reads 1, addr 3 reads 1; read_en at addr 3 -> addr 2 reads 0.
REQ-032 Sweep all four (A,B) combinations, draining Y each time -> Y values 0, 1, 1, 1.
REQ-033 Fill with 2 writes to A and no B -> addr 0 reads 0; a third A write is dropped; after 2 B writes and 2 drains, exactly 2 results are returned.
REQ-034 Writes to addresses 0-3, 6, 7 -> no flag changes; read addresses 4-7 -> read_data 0.
REQ-035 Assert RST_N=0 mid-stream with data in A and Y -> flags return to 1/1/0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/dut_pkg.sv
// Shared constants for the OR-combining FIFO block: address map and default data width.
package dut_pkg;

  localparam int unsigned DATA_W_DEF = 1;

  localparam logic [2:0] A_STAT = 3'd0;
  localparam logic [2:0] B_STAT = 3'd1;
  localparam logic [2:0] Y_STAT = 3'd2;
  localparam logic [2:0] Y_DATA = 3'd3;
  localparam logic [2:0] A_WR   = 3'd4;
  localparam logic [2:0] B_WR   = 3'd5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; enq on full and deq on empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             enq,
  input  logic [WIDTH-1:0] d_in,
  input  logic             deq,
  output logic [WIDTH-1:0] first,
  output logic             FULL_N,
  output logic             EMPTY_N
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  // Storage rounded up to a power of two so every pointer value indexes a real entry.
  localparam int unsigned MemD = 1 << PtrW;

  logic [WIDTH-1:0] mem_q [MemD];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_enq, do_deq;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    FULL_N   = (cnt_q != CntW'(DEPTH));
    EMPTY_N  = (cnt_q != '0);
    do_enq   = enq && FULL_N;
    do_deq   = deq && EMPTY_N;
    wr_ptr_d = do_enq ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_deq ? next_ptr(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CntW'(do_enq) - CntW'(do_deq);
    first    = mem_q[rd_ptr_q];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_enq) begin
      mem_q[wr_ptr_q] <= d_in;
    end
  end

endmodule

// File: rtl/dut.sv
// Two operand FIFOs feed an OR unit whose results queue in Y; status and data read by address.
module dut
  import dut_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned B_DEPTH = 2,
  parameter int unsigned Y_DEPTH = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [2:0]        write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  output logic              write_rdy,
  input  logic [2:0]        read_address,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_rdy
);

  logic              a_full_n, a_empty_n;
  logic              b_full_n, b_empty_n;
  logic              y_full_n, y_empty_n;
  logic [DATA_W-1:0] a_first, b_first, y_first;
  logic              a_enq, b_enq, compute, y_deq;

  assign write_rdy = 1'b1;
  assign read_rdy  = 1'b1;

  // All decisions use pre-edge flags, so a same-edge Y dequeue never enables a compute.
  always_comb begin
    a_enq   = write_en && (write_address == A_WR) && a_full_n;
    b_enq   = write_en && (write_address == B_WR) && b_full_n;
    compute = a_empty_n && b_empty_n && y_full_n;
    y_deq   = read_en && (read_address == Y_DATA) && y_empty_n;
  end

  always_comb begin
    read_data = '0;
    case (read_address)
      A_STAT:  read_data = DATA_W'(a_full_n);
      B_STAT:  read_data = DATA_W'(b_full_n);
      Y_STAT:  read_data = DATA_W'(y_empty_n);
      Y_DATA:  read_data = y_empty_n ? y_first : '0;
      default: read_data = '0;
    endcase
  end

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(A_DEPTH)) a_ff (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .enq     (a_enq),
    .d_in    (write_data),
    .deq     (compute),
    .first   (a_first),
    .FULL_N  (a_full_n),
    .EMPTY_N (a_empty_n)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(B_DEPTH)) b_ff (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .enq     (b_enq),
    .d_in    (write_data),
    .deq     (compute),
    .first   (b_first),
    .FULL_N  (b_full_n),
    .EMPTY_N (b_empty_n)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(Y_DEPTH)) y_ff (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .enq     (compute),
    .d_in    (a_first | b_first),
    .deq     (y_deq),
    .first   (y_first),
    .FULL_N  (y_full_n),
    .EMPTY_N (y_empty_n)
  );

endmodule

// File: tb/tb_dut.sv
// Randomized scoreboard bench for dut against a queue-based behavioural model.
module tb_dut;

  localparam int unsigned DW = 4;
  localparam int unsigned AD = 2;
  localparam int unsigned BD = 2;
  localparam int unsigned YD = 1;

  logic          CLK;
  logic          RST_N;
  logic [2:0]    write_address;
  logic [DW-1:0] write_data;
  logic          write_en;
  logic          write_rdy;
  logic [2:0]    read_address;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          read_rdy;

  dut #(.DATA_W(DW), .A_DEPTH(AD), .B_DEPTH(BD), .Y_DEPTH(YD)) u_dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  typedef struct {
    logic [2:0]    addr;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW-1:0] qy[$];
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [2:0] ra);
    case (ra)
      3'd0:    return DW'(qa.size() < AD);
      3'd1:    return DW'(qb.size() < BD);
      3'd2:    return DW'(qy.size() > 0);
      3'd3:    return (qy.size() > 0) ? qy[0] : '0;
      default: return '0;
    endcase
  endfunction

  // Apply one clock edge's worth of behaviour to the model, all decided on pre-edge contents.
  task automatic model_edge(input logic we, input logic [2:0] wa, input logic [DW-1:0] wd,
                            input logic re, input logic [2:0] ra);
    bit            do_cmp, do_ydeq, do_a, do_b;
    logic [DW-1:0] res;
    do_cmp  = (qa.size() > 0) && (qb.size() > 0) && (qy.size() < YD);
    do_ydeq = re && (ra == 3'd3) && (qy.size() > 0);
    do_a    = we && (wa == 3'd4) && (qa.size() < AD);
    do_b    = we && (wa == 3'd5) && (qb.size() < BD);
    res     = '0;
    if (do_cmp) res = qa.pop_front() | qb.pop_front();
    if (do_ydeq) void'(qy.pop_front());
    if (do_cmp) qy.push_back(res);
    if (do_a) qa.push_back(wd);
    if (do_b) qb.push_back(wd);
  endtask

  // One cycle: drive after the edge, queue the expected read result, advance the model.
  task automatic step(input logic we, input logic [2:0] wa, input logic [DW-1:0] wd,
                      input logic re, input logic [2:0] ra);
    exp_t e;
    @(posedge CLK);
    #1;
    write_en      = we;
    write_address = wa;
    write_data    = wd;
    read_en       = re;
    read_address  = ra;
    e.addr = ra;
    e.val  = model_read(ra);
    exp_q.push_back(e);
    model_edge(we, wa, wd, re, ra);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("read_data@%0d", e.addr), read_data, e.val);
      check("rdy", {write_rdy, read_rdy}, DW'(2'b11));
    end
  end

  task automatic check_reset_reads(input string tag);
    logic [DW-1:0] req [4];
    req[0] = DW'(1); req[1] = DW'(1); req[2] = '0; req[3] = '0;
    for (int i = 0; i < 8; i++) begin
      read_address = 3'(i);
      #1;
      check($sformatf("%s_rd%0d", tag, i), read_data, (i < 4) ? req[i] : '0);
    end
    check($sformatf("%s_rdy", tag), {write_rdy, read_rdy}, DW'(2'b11));
  endtask

  initial begin
    RST_N = 1'b0;
    write_en = 1'b0; write_address = '0; write_data = '0;
    read_en = 1'b0; read_address = '0;
    #3;
    check_reset_reads("in_reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Single OR result, observe latency, then drain.
    step(1, 3'd4, DW'(1), 0, 3'd2);
    step(1, 3'd5, DW'(0), 0, 3'd2);
    step(0, 3'd0, '0, 0, 3'd2);
    step(0, 3'd0, '0, 0, 3'd2);
    step(0, 3'd0, '0, 0, 3'd3);
    step(0, 3'd0, '0, 1, 3'd3);
    step(0, 3'd0, '0, 0, 3'd2);

    // All operand pairs, draining Y each time.
    for (int k = 0; k < 4; k++) begin
      step(1, 3'd4, DW'(k >> 1), 0, 3'd0);
      step(1, 3'd5, DW'(k & 1), 0, 3'd1);
      step(0, 3'd0, '0, 0, 3'd2);
      step(0, 3'd0, '0, 1, 3'd3);
      step(0, 3'd0, '0, 0, 3'd2);
    end

    // Fill A, overflow write, then feed B and drain.
    step(1, 3'd4, DW'(4'h8), 0, 3'd0);
    step(1, 3'd4, DW'(4'h2), 0, 3'd0);
    step(1, 3'd4, DW'(4'h5), 0, 3'd0);
    step(1, 3'd5, DW'(4'h1), 0, 3'd0);
    step(1, 3'd5, DW'(4'h4), 0, 3'd1);
    step(0, 3'd0, '0, 1, 3'd3);
    step(0, 3'd0, '0, 1, 3'd3);
    step(0, 3'd0, '0, 1, 3'd3);
    step(0, 3'd0, '0, 1, 3'd3);
    step(0, 3'd0, '0, 0, 3'd2);

    // Writes to non-FIFO addresses and reads of unmapped addresses.
    for (int k = 0; k < 8; k++) begin
      if (k != 4 && k != 5) step(1, 3'(k), DW'(4'hf), 1, 3'(k));
    end
    for (int k = 0; k < 3; k++) step(0, 3'd0, '0, 0, 3'(k));

    for (int n = 0; n < 3000; n++) begin
      logic [2:0] wa, ra;
      wa = ($urandom_range(0, 5) < 5) ? 3'(4 + $urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      step(1'($urandom_range(0, 1)), wa, DW'($urandom), 1'($urandom_range(0, 2) != 0), ra);
    end

    // Mid-stream reset with data held in A and Y.
    step(1, 3'd4, DW'(4'h3), 0, 3'd0);
    step(1, 3'd5, DW'(4'h4), 0, 3'd0);
    step(0, 3'd0, '0, 0, 3'd0);
    step(1, 3'd4, DW'(4'h6), 0, 3'd2);
    step(0, 3'd0, '0, 0, 3'd2);
    step(0, 3'd0, '0, 0, 3'd3);
    @(posedge CLK);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    #1;
    RST_N = 1'b0;
    check_reset_reads("async_reset");
    qa.delete(); qb.delete(); qy.delete();
    #1;
    RST_N = 1'b1;
    step(1, 3'd4, DW'(4'h9), 0, 3'd0);
    step(1, 3'd5, DW'(4'h2), 0, 3'd2);
    step(0, 3'd0, '0, 0, 3'd2);
    step(0, 3'd0, '0, 0, 3'd3);
    step(0, 3'd0, '0, 1, 3'd3);
    step(0, 3'd0, '0, 0, 3'd2);

    @(posedge CLK);
    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) check("scoreboard_drained", DW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
